timer_display: RTL and testbench

- Downstream consumer of the 16-bit event timer. Samples the timer value while the timer reports it valid.
- Converts the captured value to 5 BCD digits with an iterative double-dabble engine.
- Drives the Nexys A7 8-digit multiplexed 7-segment display: common anodes and cathodes, both active-low.
- Single clock domain, same clock as the timer.

---
 rtl/timer_display_pkg.sv | 47 ++++
 rtl/timer_display_if.sv | 21 ++
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 rtl/timer_display.sv | 146 ++++++++++++++
 tb/tb_timer_display.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_display_pkg
//  Description : Shared types, widths and the 7-segment encoder used by the
//                timer display slice (converter FSM, display top, interface).
//  Contents    : conv_state_t  - converter state encoding
//                BCD_DIGITS, BIN_W, BCD_W, SEG_BLANK
//                seg7_encode() - BCD nibble to active-low {g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_display_pkg;

  localparam int BCD_DIGITS = 5;
  localparam int BIN_W      = 16;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // All cathodes high: digit dark, decimal point off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  // Codes above 9 cannot come out of the converter; they render dark.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    logic [6:0] v_seg;
    case (nibble)
      4'd0:    v_seg = 7'b1000000;
      4'd1:    v_seg = 7'b1111001;
      4'd2:    v_seg = 7'b0100100;
      4'd3:    v_seg = 7'b0110000;
      4'd4:    v_seg = 7'b0011001;
      4'd5:    v_seg = 7'b0010010;
      4'd6:    v_seg = 7'b0000010;
      4'd7:    v_seg = 7'b1111000;
      4'd8:    v_seg = 7'b0000000;
      4'd9:    v_seg = 7'b0010000;
      default: v_seg = 7'b1111111;
    endcase
    return v_seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_display_if
//  Description : Timer-to-display value channel.
//  Signals     : t_valid - timer value valid (high while the timer counts)
//                t_value - unsigned 16-bit timer count
//  Modports    : master - timer side (drives)
//                slave  - display side (samples)
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_display_if;
  import timer_display_pkg::*;

  logic             t_valid;
  logic [BIN_W-1:0] t_value;

  modport master (output t_valid, output t_value);
  modport slave  (input  t_valid, input  t_value);

endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Iterative double-dabble binary-to-BCD converter, one bit per
//                clock. A start seen in IDLE loads the value; 16 SHIFT cycles
//                follow, then one DONE cycle in which bcd is valid.
//  Ports       : clock - system clock, rising edge
//                reset - asynchronous, active-high
//                start - load bin (honoured in IDLE only)
//                bin   - 16-bit binary input
//                busy  - high in SHIFT and DONE
//                bcd   - 5 BCD nibbles, valid while done is high
//                done  - one-cycle result strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import timer_display_pkg::*;
(
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic [BIN_W-1:0] bin,
  output logic                  busy,
  output logic [BCD_W-1:0]      bcd,
  output logic                  done
);

  localparam int         c_sh_w     = BCD_W + BIN_W;
  localparam logic [3:0] c_last_itr = 4'd15;

  conv_state_t       r_state;
  conv_state_t       w_state_next;
  logic [c_sh_w-1:0] r_shift;
  logic [c_sh_w-1:0] w_adj;
  logic [3:0]        r_iter;
  logic              w_busy;
  logic              w_done;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and status outputs
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (r_iter == c_last_itr) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
  // following left shift carries correctly into the next decade.
  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_shift[BIN_W + 4*i +: 4] >= 4'd5) begin
        w_adj[BIN_W + 4*i +: 4] = r_shift[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_iter  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= {{BCD_W{1'b0}}, bin};
            r_iter  <= '0;
          end
        end
        SHIFT: begin
          r_shift <= {w_adj[c_sh_w-2:0], 1'b0};
          r_iter  <= r_iter + 4'd1;
        end
        default: begin
          r_shift <= r_shift;
        end
      endcase
    end
  end

  assign busy = w_busy;
  assign done = w_done;
  assign bcd  = r_shift[c_sh_w-1 -: BCD_W];

endmodule
`default_nettype wire

// File: rtl/timer_display.sv
`default_nettype none
// ============================================================================
//  Module      : timer_display
//  Description : Samples the event timer while it reports valid, converts the
//                value to BCD and scans it onto the Nexys A7 8-digit
//                multiplexed 7-segment display (anodes and cathodes active-low).
//  Parameters  : SCAN_DIV - clock cycles each digit stays lit (2..2^20)
//  Macro       : LEADING_ZERO_BLANK_EN - when defined, digits 4..1 go dark
//                while they and every higher digit are zero
//  Ports       : reset   - asynchronous, active-high
//                clock   - system clock, rising edge
//                tif     - timer value channel (t_valid, t_value), slave side
//                busy    - conversion in progress
//                bcd_out - displayed value, 5 BCD nibbles, [3:0] = units
//                an      - digit anodes, active-low, an[0] = rightmost
//                seg     - cathodes {dp,g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_display
  import timer_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  wire logic        reset,
  input  wire logic        clock,
  timer_display_if.slave   tif,
  output logic             busy,
  output logic [BCD_W-1:0] bcd_out,
  output logic [7:0]       an,
  output logic [7:0]       seg
);

  localparam int                c_pre_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);

  logic             w_busy;
  logic             w_done;
  logic             w_start;
  logic [BCD_W-1:0] w_bcd;
  logic [BCD_W-1:0] r_bcd_out;

  logic [c_pre_w-1:0]    r_pre;
  logic [2:0]            r_digit;
  logic [7:0]            r_an;
  logic [7:0]            r_seg;
  logic [3:0]            w_nibble;
  logic [BCD_DIGITS-1:0] w_lz;
  logic [7:0]            w_digit_blank;
  logic                  w_blank;
  logic [7:0]            w_an_next;
  logic [7:0]            w_seg_next;

  // --------------------------------------------------------------------------
  // Capture: a valid value is taken only when the converter is idle; values
  // offered during a conversion are dropped, not queued.
  // --------------------------------------------------------------------------
  assign w_start = tif.t_valid & ~w_busy;

  bin2bcd_seq u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (w_start),
    .bin   (tif.t_value),
    .busy  (w_busy),
    .bcd   (w_bcd),
    .done  (w_done)
  );

  // Held between conversions, so the display freezes once t_valid drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bcd_out <= '0;
    end else if (w_done) begin
      r_bcd_out <= w_bcd;
    end
  end

  // --------------------------------------------------------------------------
  // Digit selection and blanking
  // --------------------------------------------------------------------------
  always_comb begin
    w_nibble = 4'd0;
    case (r_digit)
      3'd0:    w_nibble = r_bcd_out[3:0];
      3'd1:    w_nibble = r_bcd_out[7:4];
      3'd2:    w_nibble = r_bcd_out[11:8];
      3'd3:    w_nibble = r_bcd_out[15:12];
      3'd4:    w_nibble = r_bcd_out[19:16];
      default: w_nibble = 4'd0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 is never blanked so a zero count still shows "0".
  always_comb begin
    logic v_upper_zero;
    w_lz         = '0;
    v_upper_zero = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      v_upper_zero = v_upper_zero & (r_bcd_out[4*i +: 4] == 4'd0);
      w_lz[i]      = v_upper_zero;
    end
  end
`else
  assign w_lz = '0;
`endif

  // Positions 7..5 have no digit behind them and are always dark.
  assign w_digit_blank = {3'b111, w_lz};
  assign w_blank       = w_digit_blank[r_digit];
  assign w_an_next     = w_blank ? 8'hFF : ~(8'd1 << r_digit);
  assign w_seg_next    = w_blank ? SEG_BLANK : {1'b1, seg7_encode(w_nibble)};

  // --------------------------------------------------------------------------
  // Scan: the prescaler sets the dwell per digit. an/seg are loaded together
  // on the first cycle of each dwell, so a new bcd_out appears at the next
  // digit change and never mid-digit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre   <= '0;
      r_digit <= 3'd0;
      r_an    <= 8'hFF;
      r_seg   <= SEG_BLANK;
    end else begin
      if (r_pre == c_pre_last) begin
        r_pre   <= '0;
        r_digit <= r_digit + 3'd1;
      end else begin
        r_pre   <= r_pre + 1'b1;
      end
      if (r_pre == '0) begin
        r_an  <= w_an_next;
        r_seg <= w_seg_next;
      end
    end
  end

  assign busy    = w_busy;
  assign bcd_out = r_bcd_out;
  assign an      = r_an;
  assign seg     = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_timer_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_display
//  Description : Self-checking bench for timer_display with SCAN_DIV=4.
//                A cycle-level behavioural model (decimal arithmetic and a
//                scan-slot counter) is compared against every output on every
//                falling edge; directed literal checks pin the model.
//  Macro       : LEADING_ZERO_BLANK_EN - enables the blanking expectations
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_display;

  localparam int SD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        busy;
  logic [19:0] bcd_out;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        cmp_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  timer_display_if tif ();

  timer_display #(.SCAN_DIV(SD)) dut (
    .reset   (reset),
    .clock   (clock),
    .tif     (tif),
    .busy    (busy),
    .bcd_out (bcd_out),
    .an      (an),
    .seg     (seg)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------- behavioural model ----------------------------
  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit is_blank(input int d, input logic [19:0] b);
    if (d >= 5) return 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (b >> (4*d)) == 20'd0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_an(input int d, input logic [19:0] b);
    if (is_blank(d, b)) return 8'hFF;
    return ~(8'd1 << d);
  endfunction

  function automatic logic [7:0] exp_seg(input int d, input logic [19:0] b);
    int nib;
    if (is_blank(d, b)) return 8'hFF;
    nib = int'((b >> (4*d)) & 20'hF);
    if (nib > 9) return 8'hFF;
    return {1'b1, seg_tab[nib]};
  endfunction

  // m_cnt: 0 = idle, 1..17 = cycles into a conversion (result lands on 17->0)
  // m_k  : clock edges since reset; each SD-edge slot shows digit (k/SD)%8
  int          m_cnt = 0;
  logic [15:0] m_val = '0;
  logic [19:0] m_bcd = '0;
  int          m_k   = 0;
  logic [7:0]  m_an  = 8'hFF;
  logic [7:0]  m_seg = 8'hFF;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt <= 0;
      m_bcd <= '0;
      m_k   <= 0;
      m_an  <= 8'hFF;
      m_seg <= 8'hFF;
    end else begin
      if (m_cnt == 0) begin
        if (tif.t_valid === 1'b1) begin
          m_cnt <= 1;
          m_val <= tif.t_value;
        end
      end else if (m_cnt == 17) begin
        m_cnt <= 0;
        m_bcd <= to_bcd(int'(m_val));
      end else begin
        m_cnt <= m_cnt + 1;
      end
      if (m_k % SD == 0) begin
        m_an  <= exp_an((m_k / SD) % 8, m_bcd);
        m_seg <= exp_seg((m_k / SD) % 8, m_bcd);
      end
      m_k <= m_k + 1;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
      check("model_bcd_out", {12'd0, bcd_out}, {12'd0, m_bcd});
      check("model_an", {24'd0, an}, {24'd0, m_an});
      check("model_seg", {24'd0, seg}, {24'd0, m_seg});
    end
  end

  // ------------------------------- stimulus ----------------------------------
  task automatic pulse(input logic [15:0] v);
    @(negedge clock);
    tif.t_valid = 1'b1;
    tif.t_value = v;
    @(negedge clock);
    tif.t_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({name, "_idle_timeout"}, {31'd0, (n < 40)}, 32'd1);
  endtask

  // Land on the first sampled cycle in which digit 0 is lit.
  task automatic wait_digit0(input string name);
    int n;
    n = 0;
    while (an == 8'hFE && n < 100) begin
      @(negedge clock);
      n++;
    end
    while (an != 8'hFE && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({name, "_scan_timeout"}, {31'd0, (n < 100)}, 32'd1);
  endtask

  logic [7:0] lit_an  [0:4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF};
  logic [7:0] lit_seg [0:4] = '{8'b10010010, 8'b10011001, 8'b10110000,
                                8'b10100100, 8'b11111001};

  initial begin
    int n;
    tif.t_valid = 1'b0;
    tif.t_value = '0;
    #1;
    reset  = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_an", {24'd0, an}, 32'hFF);
    check("reset_seg", {24'd0, seg}, 32'hFF);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_bcd", {12'd0, bcd_out}, 32'd0);
    reset = 1'b0;

    // 12345: busy length, result, and the full scan pattern
    pulse(16'd12345);
    wait_idle("c12345", n);
    check("busy_len", n, 32'd17);
    check("bcd_12345", {12'd0, bcd_out}, 32'h12345);
    wait_digit0("c12345");
    for (int d = 0; d < 5; d++) begin
      check("scan_an", {24'd0, an}, {24'd0, lit_an[d]});
      check("scan_seg", {24'd0, seg}, {24'd0, lit_seg[d]});
      repeat (SD) @(negedge clock);
    end
    for (int i = 0; i < 12; i++) begin
      check("scan_blank_an", {24'd0, an}, 32'hFF);
      @(negedge clock);
    end

    // Extremes
    pulse(16'd65535);
    wait_idle("c65535", n);
    check("bcd_65535", {12'd0, bcd_out}, 32'h65535);
    pulse(16'd0);
    wait_idle("c0", n);
    check("bcd_0", {12'd0, bcd_out}, 32'h0);
    wait_digit0("c0");
    check("zero_seg", {24'd0, seg}, 32'hC0);

    // A pulse at E5 of a running conversion is dropped
    pulse(16'd100);
    repeat (3) @(negedge clock);
    pulse(16'd999);
    wait_idle("c100", n);
    check("bcd_100_ignore", {12'd0, bcd_out}, 32'h00100);
    pulse(16'd999);
    wait_idle("c999", n);
    check("bcd_999", {12'd0, bcd_out}, 32'h00999);

    // Held valid with a counting value: captures at E0, E18, E36
    @(negedge clock);
    tif.t_valid = 1'b1;
    tif.t_value = 16'd200;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 18) check("hold_bcd_200", {12'd0, bcd_out}, 32'h00200);
      if (i == 36) check("hold_bcd_218", {12'd0, bcd_out}, 32'h00218);
      tif.t_value = tif.t_value + 16'd1;
    end
    tif.t_valid = 1'b0;
    wait_idle("hold", n);
    repeat (30) @(negedge clock);
    check("freeze_bcd_236", {12'd0, bcd_out}, 32'h00236);

    // Asynchronous reset at E8 of a conversion
    pulse(16'd4321);
    repeat (7) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bcd", {12'd0, bcd_out}, 32'd0);
    check("abort_an", {24'd0, an}, 32'hFF);
    @(negedge clock);
    reset = 1'b0;
    pulse(16'd7);
    wait_idle("c7", n);
    check("bcd_7", {12'd0, bcd_out}, 32'h00007);
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
`ifdef LEADING_ZERO_BLANK_EN
      check("lzb_only_an0", {31'd0, (an == 8'hFE || an == 8'hFF)}, 32'd1);
`endif
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
